// File: rtl/natalius_mem_arbiter_if.sv
// Pin bundle for natalius_mem_arbiter: Wishbone slave pins, VGA fetch port and SRAM macro pins.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface natalius_mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [DW/8-1:0]   wbs_sel_i;
  logic [AW-1:0]     wbs_adr_i;
  logic [DW-1:0]     wbs_dat_i;
  logic [DW-1:0]     wbs_dat_o;
  logic              wbs_ack_o;

  logic              vid_req;
  logic [AW-1:0]     vid_addr;
  logic              vid_gnt;
  logic              vid_valid;
  logic [DW-1:0]     vid_data;

  logic              mem_csb;
  logic              mem_web;
  logic [DW/8-1:0]   mem_wmask;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_din;
  logic [DW-1:0]     mem_dout;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_dat_o, wbs_ack_o,
    input  vid_req, vid_addr,
    output vid_gnt, vid_valid, vid_data,
    output mem_csb, mem_web, mem_wmask, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_dat_o, wbs_ack_o,
    output vid_req, vid_addr,
    input  vid_gnt, vid_valid, vid_data,
    input  mem_csb, mem_web, mem_wmask, mem_addr, mem_din,
    output mem_dout
  );
endinterface

// File: rtl/natalius_mem_arbiter.sv
// Shares the natalius_soc single-port SRAM between the Wishbone host and the VGA line fetcher.
// Define NATALIUS_ARB_FAIRNESS_EN to add the starve counter that bounds host wait time.
module natalius_mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
`ifdef NATALIUS_ARB_FAIRNESS_EN
  ,
  parameter int STARVE_MAX = 4
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  natalius_mem_arbiter_if.slave bus
);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    HOST_CAP,
    HOST_ACK
  } state_t;

  state_t          state_q, state_d;
  logic            wbAck_q, wbAck_d;
  logic [DW-1:0]   wbData_q, wbData_d;
  logic            vidValid_q, vidValid_d;
  logic [DW-1:0]   vidData_q, vidData_d;

  logic            hostPend;
  logic            hostWin;
  logic            vidWin;
  logic            starveHit;

  logic            memCsb;
  logic            memWeb;
  logic [BW-1:0]   memWmask;
  logic [AW-1:0]   memAddr;
  logic [DW-1:0]   memDin;

`ifdef NATALIUS_ARB_FAIRNESS_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0]   starveCnt_q, starveCnt_d;

  assign starveHit = (starveCnt_q == CW'(STARVE_MAX));

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!hostPend || hostWin) begin
      starveCnt_d = '0;
    end else if (vidWin && !starveHit) begin
      starveCnt_d = starveCnt_q + CW'(1);
    end
  end
`else
  assign starveHit = 1'b0;
`endif

  // Video wins ties; the host only overtakes it once the starve limit is reached.
  always_comb begin
    hostPend = bus.wbs_cyc_i & bus.wbs_stb_i;
    hostWin  = (state_q == IDLE) & hostPend & (~bus.vid_req | starveHit);
    vidWin   = (state_q == IDLE) & bus.vid_req & ~hostWin;
  end

  always_comb begin
    memCsb   = 1'b1;
    memWeb   = 1'b1;
    memWmask = '0;
    memAddr  = '0;
    memDin   = '0;
    if (vidWin) begin
      memCsb  = 1'b0;
      memAddr = bus.vid_addr;
    end else if (hostWin) begin
      memCsb  = 1'b0;
      memAddr = bus.wbs_adr_i;
      if (bus.wbs_we_i) begin
        memWeb   = 1'b0;
        memWmask = bus.wbs_sel_i;
        memDin   = bus.wbs_dat_i;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wbAck_d    = 1'b0;
    wbData_d   = wbData_q;
    vidValid_d = vidWin;
    vidData_d  = vidValid_q ? bus.mem_dout : vidData_q;
    case (state_q)
      IDLE: begin
        if (hostWin) begin
          state_d = bus.wbs_we_i ? HOST_ACK : HOST_CAP;
          wbAck_d = bus.wbs_we_i;
        end
      end
      HOST_CAP: begin
        if (!bus.wbs_cyc_i) begin
          state_d = IDLE;
        end else begin
          state_d  = HOST_ACK;
          wbAck_d  = 1'b1;
          wbData_d = bus.mem_dout;
        end
      end
      HOST_ACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wbAck_q     <= 1'b0;
      wbData_q    <= '0;
      vidValid_q  <= 1'b0;
      vidData_q   <= '0;
`ifdef NATALIUS_ARB_FAIRNESS_EN
      starveCnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wbAck_q     <= wbAck_d;
      wbData_q    <= wbData_d;
      vidValid_q  <= vidValid_d;
      vidData_q   <= vidData_d;
`ifdef NATALIUS_ARB_FAIRNESS_EN
      starveCnt_q <= starveCnt_d;
`endif
    end
  end

  // Dropping cyc during the ack cycle must still suppress the ack, hence the gate.
  assign bus.wbs_ack_o = wbAck_q & bus.wbs_cyc_i;
  assign bus.wbs_dat_o = wbData_q;
  assign bus.vid_gnt   = vidWin;
  assign bus.vid_valid = vidValid_q;
  assign bus.vid_data  = vidData_q;
  assign bus.mem_csb   = memCsb;
  assign bus.mem_web   = memWeb;
  assign bus.mem_wmask = memWmask;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_din   = memDin;
endmodule

// File: tb/tb_natalius_mem_arbiter.sv
// Bench for natalius_mem_arbiter: SRAM model plus scenario tasks with a read-data scoreboard.
// Expectations follow NATALIUS_ARB_FAIRNESS_EN the same way the design does.
`timescale 1ns/1ps
module tb_natalius_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] expQ[$];
  logic [DW-1:0] sram [0:(1<<AW)-1];

  natalius_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  natalius_mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // SRAM model: reset preloads 0x1000+addr into words 0..7, read data lands the cycle after access.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < (1 << AW); i++) sram[i] <= (i < 8) ? 16'(32'h1000 + i) : 16'h0000;
      bus.mem_dout <= '0;
    end else if (!bus.mem_csb) begin
      if (!bus.mem_web) begin
        for (int b = 0; b < DW/8; b++)
          if (bus.mem_wmask[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_din[8*b +: 8];
      end else begin
        bus.mem_dout <= sram[bus.mem_addr];
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;
    bus.vid_req   = 1'b0;
    bus.vid_addr  = '0;
  endtask

  task automatic test_reset;
    logic [DW-1:0] exp;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_ack: got %0h expected 0", bus.wbs_ack_o); end
    checks++; if (bus.wbs_dat_o !== 16'h0) begin failures++; $display("[TB] FAIL rst_dat: got %0h expected 0", bus.wbs_dat_o); end
    checks++; if (bus.vid_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_vvalid: got %0h expected 0", bus.vid_valid); end
    checks++; if (bus.vid_data !== 16'h0) begin failures++; $display("[TB] FAIL rst_vdata: got %0h expected 0", bus.vid_data); end
    checks++; if (bus.vid_gnt !== 1'b0) begin failures++; $display("[TB] FAIL rst_gnt: got %0h expected 0", bus.vid_gnt); end
    checks++; if (bus.mem_csb !== 1'b1 || bus.mem_web !== 1'b1) begin failures++; $display("[TB] FAIL rst_mem: got csb=%0h web=%0h expected 1/1", bus.mem_csb, bus.mem_web); end
    stepCycle();
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 12'h005;
    @(negedge clk);
    checks++; if (bus.mem_csb !== 1'b0) begin failures++; $display("[TB] FAIL pre_rst_grant: got csb=%0h expected 0", bus.mem_csb); end
    stepCycle();
    #1;
    rst = 1'b0;
    idleInputs();
    #1;
    checks++; if (bus.wbs_ack_o !== 1'b0 || bus.mem_csb !== 1'b1 || bus.vid_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_out: got ack=%0h csb=%0h vvalid=%0h expected 0/1/0", bus.wbs_ack_o, bus.mem_csb, bus.vid_valid); end
    stepCycle();
    @(negedge clk);
    checks++; if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 16'h0) begin failures++; $display("[TB] FAIL midrst_noack: got ack=%0h dat=%0h expected 0/0", bus.wbs_ack_o, bus.wbs_dat_o); end
    stepCycle();
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 12'h005;
    @(negedge clk);
    checks++; if (bus.mem_csb !== 1'b0 || bus.mem_web !== 1'b1 || bus.mem_addr !== 12'h005) begin failures++; $display("[TB] FAIL post_rst_grant: got csb=%0h web=%0h addr=%0h expected 0/1/005", bus.mem_csb, bus.mem_web, bus.mem_addr); end
    expQ.push_back(16'h1005);
    stepCycle();
    @(negedge clk);
    checks++; if (bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL post_rst_cap: got ack=%0h expected 0", bus.wbs_ack_o); end
    stepCycle();
    @(negedge clk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
    checks++; if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== exp) begin failures++; $display("[TB] FAIL post_rst_read: got ack=%0h dat=%0h expected 1/%0h", bus.wbs_ack_o, bus.wbs_dat_o, exp); end
    stepCycle();
    idleInputs();
    @(negedge clk);
    checks++; if (bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL post_rst_ack_once: got %0h expected 0", bus.wbs_ack_o); end
    stepCycle();
  endtask

  task automatic test_write_read;
    logic [DW-1:0] exp;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = 12'h123; bus.wbs_dat_i = 16'hBEEF; bus.wbs_sel_i = 2'b10;
    @(negedge clk);
    checks++; if (bus.mem_csb !== 1'b0 || bus.mem_web !== 1'b0 || bus.mem_wmask !== 2'b10) begin failures++; $display("[TB] FAIL wr_ctl: got csb=%0h web=%0h mask=%0h expected 0/0/2", bus.mem_csb, bus.mem_web, bus.mem_wmask); end
    checks++; if (bus.mem_addr !== 12'h123 || bus.mem_din !== 16'hBEEF) begin failures++; $display("[TB] FAIL wr_bus: got addr=%0h din=%0h expected 123/beef", bus.mem_addr, bus.mem_din); end
    checks++; if (bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL wr_early_ack: got %0h expected 0", bus.wbs_ack_o); end
    stepCycle();
    @(negedge clk);
    checks++; if (bus.wbs_ack_o !== 1'b1 || bus.mem_csb !== 1'b1) begin failures++; $display("[TB] FAIL wr_ack: got ack=%0h csb=%0h expected 1/1", bus.wbs_ack_o, bus.mem_csb); end
    stepCycle();
    idleInputs();
    @(negedge clk);
    checks++; if (bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL wr_ack_once: got %0h expected 0", bus.wbs_ack_o); end
    stepCycle();
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = 12'h123; bus.wbs_sel_i = 2'b11;
    @(negedge clk);
    checks++; if (bus.mem_csb !== 1'b0 || bus.mem_web !== 1'b1 || bus.mem_wmask !== 2'b00) begin failures++; $display("[TB] FAIL rd_ctl: got csb=%0h web=%0h mask=%0h expected 0/1/0", bus.mem_csb, bus.mem_web, bus.mem_wmask); end
    expQ.push_back(16'hBE00);
    stepCycle();
    @(negedge clk);
    checks++; if (bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL rd_cap_ack: got %0h expected 0", bus.wbs_ack_o); end
    stepCycle();
    @(negedge clk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
    checks++; if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== exp) begin failures++; $display("[TB] FAIL rd_data: got ack=%0h dat=%0h expected 1/%0h", bus.wbs_ack_o, bus.wbs_dat_o, exp); end
    stepCycle();
    idleInputs();
    @(negedge clk);
    checks++; if (bus.mem_csb !== 1'b1 || bus.mem_addr !== 12'h0 || bus.mem_din !== 16'h0 || bus.mem_wmask !== 2'b00) begin failures++; $display("[TB] FAIL idle_mem: got csb=%0h addr=%0h din=%0h mask=%0h expected 1/0/0/0", bus.mem_csb, bus.mem_addr, bus.mem_din, bus.mem_wmask); end
    checks++; if (bus.wbs_dat_o !== 16'hBE00) begin failures++; $display("[TB] FAIL dat_hold: got %0h expected be00", bus.wbs_dat_o); end
    stepCycle();
  endtask

  task automatic test_video_burst;
    int gnts = 0;
    int valids = 0;
    logic expG, expV;
    logic [DW-1:0] exp;
    for (int c = 0; c < 11; c++) begin
      bus.vid_req  = (c < 8);
      bus.vid_addr = (c < 8) ? AW'(c) : '0;
      @(negedge clk);
      expG = (c < 8);
      expV = (c >= 1 && c < 9);
      if (bus.vid_gnt) begin gnts++; expQ.push_back(16'(32'h1000 + c)); end
      if (bus.vid_valid) valids++;
      checks++; if (bus.vid_gnt !== expG) begin failures++; $display("[TB] FAIL burst_gnt c=%0d: got %0h expected %0h", c, bus.vid_gnt, expG); end
      checks++; if (bus.vid_valid !== expV) begin failures++; $display("[TB] FAIL burst_valid c=%0d: got %0h expected %0h", c, bus.vid_valid, expV); end
      if (c < 8) begin
        checks++; if (bus.mem_addr !== AW'(c) || bus.mem_web !== 1'b1 || bus.mem_wmask !== 2'b00) begin failures++; $display("[TB] FAIL burst_mem c=%0d: got addr=%0h web=%0h mask=%0h expected %0h/1/0", c, bus.mem_addr, bus.mem_web, bus.mem_wmask, c); end
      end
      if (c >= 2 && c < 10) begin
        exp = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
        checks++; if (bus.vid_data !== exp) begin failures++; $display("[TB] FAIL burst_data c=%0d: got %0h expected %0h", c, bus.vid_data, exp); end
      end
      stepCycle();
    end
    checks++; if (gnts != 8 || valids != 8) begin failures++; $display("[TB] FAIL burst_counts: got gnt=%0d valid=%0d expected 8/8", gnts, valids); end
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL burst_sb_left: got %0d expected 0", expQ.size()); end
    expQ.delete();
  endtask

  task automatic test_fairness;
    int vidGrants = 0;
    int hostCycle = -1;
    logic [DW-1:0] exp;
    bus.vid_req = 1'b1; bus.vid_addr = 12'h010;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 12'h006;
    for (int c = 0; c < 12 && hostCycle < 0; c++) begin
      @(negedge clk);
      if (!bus.mem_csb && !bus.vid_gnt) begin
        hostCycle = c;
        expQ.push_back(16'h1006);
      end else if (bus.vid_gnt) begin
        vidGrants++;
      end
      stepCycle();
    end
`ifdef NATALIUS_ARB_FAIRNESS_EN
    checks++; if (hostCycle < 0 || vidGrants != STARVE) begin failures++; $display("[TB] FAIL fair_grants: got host_cycle=%0d vid=%0d expected host after %0d", hostCycle, vidGrants, STARVE); end
    @(negedge clk);
    checks++; if (bus.vid_gnt !== 1'b0) begin failures++; $display("[TB] FAIL fair_cap_gnt: got %0h expected 0", bus.vid_gnt); end
    stepCycle();
`else
    checks++; if (hostCycle != -1 || vidGrants != 12) begin failures++; $display("[TB] FAIL strict_grants: got host_cycle=%0d vid=%0d expected -1/12", hostCycle, vidGrants); end
    bus.vid_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.mem_csb !== 1'b0 || bus.vid_gnt !== 1'b0 || bus.mem_addr !== 12'h006) begin failures++; $display("[TB] FAIL strict_host_grant: got csb=%0h gnt=%0h addr=%0h expected 0/0/006", bus.mem_csb, bus.vid_gnt, bus.mem_addr); end
    expQ.push_back(16'h1006);
    stepCycle();
    bus.vid_req = 1'b1;
    @(negedge clk);
    checks++; if (bus.vid_gnt !== 1'b0) begin failures++; $display("[TB] FAIL strict_cap_gnt: got %0h expected 0", bus.vid_gnt); end
    stepCycle();
`endif
    @(negedge clk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
    checks++; if (bus.wbs_ack_o !== 1'b1 || bus.wbs_dat_o !== exp || bus.vid_gnt !== 1'b0) begin failures++; $display("[TB] FAIL arb_ack: got ack=%0h dat=%0h gnt=%0h expected 1/%0h/0", bus.wbs_ack_o, bus.wbs_dat_o, bus.vid_gnt, exp); end
    stepCycle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.vid_gnt !== 1'b1) begin failures++; $display("[TB] FAIL arb_vid_resume: got %0h expected 1", bus.vid_gnt); end
    stepCycle();
    idleInputs();
    repeat (3) stepCycle();
    expQ.delete();
  endtask

  task automatic test_abort;
    logic [DW-1:0] exp;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0; bus.wbs_adr_i = 12'h002;
    @(negedge clk);
    checks++; if (bus.mem_csb !== 1'b0 || bus.vid_gnt !== 1'b0) begin failures++; $display("[TB] FAIL abort_grant: got csb=%0h gnt=%0h expected 0/0", bus.mem_csb, bus.vid_gnt); end
    stepCycle();
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    bus.vid_req = 1'b1; bus.vid_addr = 12'h003;
    @(negedge clk);
    checks++; if (bus.vid_gnt !== 1'b0 || bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_cap: got gnt=%0h ack=%0h expected 0/0", bus.vid_gnt, bus.wbs_ack_o); end
    stepCycle();
    @(negedge clk);
    checks++; if (bus.vid_gnt !== 1'b1 || bus.mem_addr !== 12'h003 || bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_vid: got gnt=%0h addr=%0h ack=%0h expected 1/003/0", bus.vid_gnt, bus.mem_addr, bus.wbs_ack_o); end
    if (bus.vid_gnt) expQ.push_back(16'h1003);
    stepCycle();
    bus.vid_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.vid_valid !== 1'b1 || bus.wbs_ack_o !== 1'b0) begin failures++; $display("[TB] FAIL abort_valid: got vvalid=%0h ack=%0h expected 1/0", bus.vid_valid, bus.wbs_ack_o); end
    stepCycle();
    @(negedge clk);
    exp = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
    checks++; if (bus.vid_data !== exp || bus.vid_valid !== 1'b0) begin failures++; $display("[TB] FAIL abort_vdata: got data=%0h vvalid=%0h expected %0h/0", bus.vid_data, bus.vid_valid, exp); end
    stepCycle();
    idleInputs();
  endtask

  initial begin
    idleInputs();
    rst = 1'b0;
    test_reset();
    test_write_read();
    test_video_burst();
    test_fairness();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
